// File: rtl/i2c_reg_bank_pkg.sv
// +-----------------------------------------------------------------------------
// | Module      : i2c_reg_bank_pkg
// | Description : Shared address map, STATUS bit indices and FSM encoding for
// |               the I2C register bank.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package i2c_reg_bank_pkg;

   localparam logic [7:0] ADDR_ID       = 8'd0;
   localparam logic [7:0] ADDR_STATUS   = 8'd1;
   localparam logic [7:0] ADDR_LED      = 8'd2;
   localparam logic [7:0] ADDR_IRQ_MASK = 8'd3;
   localparam logic [7:0] ADDR_SCRATCH  = 8'd4;

   localparam int ST_COLL    = 6;
   localparam int ST_PTR_OVF = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PTR  = 2'd1,
      ST_DATA = 2'd2
   } bank_state_t;

   // Pointer advance with wrap at the last implemented address.
   function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input logic [7:0] last);
      return (ptr == last) ? 8'd0 : ptr + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_reg_bank_status_w1c.sv
// +-----------------------------------------------------------------------------
// | Module      : i2c_status_w1c
// | Description : 8-bit sticky status register, write-1-to-clear with set
// |               priority, masked into a registered interrupt.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module i2c_status_w1c (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_set,
   input  logic       i_clr_we,
   input  logic [7:0] i_clr_data,
   input  logic [7:0] i_mask,
   output logic [7:0] o_status,
   output logic       o_irq
);

   logic [7:0] r_status;
   logic       r_irq;
   logic [7:0] w_clr;

   assign w_clr = i_clr_we ? i_clr_data : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_status <= 8'h00;
         r_irq    <= 1'b0;
      end else begin
         r_status <= (r_status & ~w_clr) | i_set;
         r_irq    <= |(r_status & i_mask);
      end
   end

   assign o_status = r_status;
   assign o_irq    = r_irq;

endmodule

`default_nettype wire

// File: rtl/i2c_reg_bank.sv
// +-----------------------------------------------------------------------------
// | Module      : i2c_reg_bank
// | Description : Byte-oriented register bank behind the I2C slave sequencer:
// |               pointer load, auto-incrementing burst access, ID/STATUS/LED.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module i2c_reg_bank #(
   parameter int         MEMORY_MAP_SIZE = 50,
   parameter logic [7:0] ID_VALUE        = 8'hA5,
   parameter             INTQ_OPENDRAIN  = "ON"
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       txn_start_i,
   input  logic       wr_valid_i,
   input  logic [7:0] wr_data_i,
   input  logic       rd_req_i,
   output logic       rd_valid_o,
   output logic [7:0] rd_data_o,
   input  logic       txn_stop_i,
   input  logic [5:0] evt_i,
   output logic [7:0] led_o,
   output logic       irq_o,
   output logic [7:0] ptr_o
);

   import i2c_reg_bank_pkg::*;

   localparam int         c_SCR_N = MEMORY_MAP_SIZE - 4;
   localparam int         c_SCR_W = (c_SCR_N > 1) ? $clog2(c_SCR_N) : 1;
   localparam logic [7:0] c_LAST  = 8'(MEMORY_MAP_SIZE - 1);
   localparam logic [8:0] c_SIZE9 = 9'(MEMORY_MAP_SIZE);

   bank_state_t r_state, w_state_nxt;
   logic [7:0]  r_ptr, w_ptr_nxt;
   logic        w_reg_we, w_rd_fire, w_coll, w_ovf;

   logic [7:0]  r_led, r_mask;
   logic [7:0]  r_scratch [c_SCR_N];
   logic [7:0]  r_rd_data;
   logic        r_rd_valid;

   logic [7:0]  w_status;
   logic        w_irq;
   logic [7:0]  w_rd_byte;
   logic [c_SCR_W-1:0] w_scr_idx;

   assign w_scr_idx = c_SCR_W'(r_ptr - ADDR_SCRATCH);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_ptr   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // A write strobe always wins over a simultaneous read request.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_reg_we    = 1'b0;
      w_rd_fire   = 1'b0;
      w_coll      = 1'b0;
      w_ovf       = 1'b0;
      if (txn_start_i) begin
         w_state_nxt = ST_PTR;
      end else begin
         if (wr_valid_i) begin
            w_coll = rd_req_i;
            case (r_state)
               ST_PTR: begin
                  if ({1'b0, wr_data_i} >= c_SIZE9) begin
                     w_ptr_nxt = 8'd0;
                     w_ovf     = 1'b1;
                  end else begin
                     w_ptr_nxt = wr_data_i;
                  end
                  w_state_nxt = ST_DATA;
               end
               ST_DATA: begin
                  w_reg_we  = 1'b1;
                  w_ptr_nxt = ptr_inc(r_ptr, c_LAST);
               end
               default: w_coll = 1'b1;
            endcase
         end else if (rd_req_i) begin
            w_rd_fire = 1'b1;
            w_ptr_nxt = ptr_inc(r_ptr, c_LAST);
            if (r_state == ST_PTR) begin
               w_state_nxt = ST_DATA;
            end
         end
         if (txn_stop_i) begin
            w_state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_led  <= 8'hFF;
         r_mask <= 8'h00;
         for (int i = 0; i < c_SCR_N; i++) begin
            r_scratch[i] <= 8'h00;
         end
      end else if (w_reg_we) begin
         if (r_ptr == ADDR_LED) begin
            r_led <= wr_data_i;
         end
         if (r_ptr == ADDR_IRQ_MASK) begin
            r_mask <= wr_data_i;
         end
         if (r_ptr >= ADDR_SCRATCH) begin
            r_scratch[w_scr_idx] <= wr_data_i;
         end
      end
   end

   i2c_status_w1c u_status (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .i_set      ({w_ovf, w_coll, evt_i}),
      .i_clr_we   (w_reg_we && (r_ptr == ADDR_STATUS)),
      .i_clr_data (wr_data_i),
      .i_mask     (r_mask),
      .o_status   (w_status),
      .o_irq      (w_irq)
   );

   always_comb begin
      w_rd_byte = 8'h00;
      case (r_ptr)
         ADDR_ID:       w_rd_byte = ID_VALUE;
         ADDR_STATUS:   w_rd_byte = w_status;
         ADDR_LED:      w_rd_byte = r_led;
         ADDR_IRQ_MASK: w_rd_byte = r_mask;
         default:       w_rd_byte = r_scratch[w_scr_idx];
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= 8'h00;
      end else begin
         r_rd_valid <= w_rd_fire;
         if (w_rd_fire) begin
            r_rd_data <= w_rd_byte;
         end
      end
   end

   generate
      if (INTQ_OPENDRAIN == "ON") begin : g_irq_od
         assign irq_o = ~w_irq;
      end else begin : g_irq_pp
         assign irq_o = w_irq;
      end
   endgenerate

   assign rd_valid_o = r_rd_valid;
   assign rd_data_o  = r_rd_data;
   assign led_o      = r_led;
   assign ptr_o      = r_ptr;

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_bank.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_i2c_reg_bank
// | Description : Directed stimulus with a read-data scoreboard for i2c_reg_bank.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_i2c_reg_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       txn_start = 1'b0;
   logic       wr_valid  = 1'b0;
   logic [7:0] wr_data   = 8'h00;
   logic       rd_req    = 1'b0;
   logic       txn_stop  = 1'b0;
   logic [5:0] evt       = 6'h00;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic [7:0] led;
   logic       irq;
   logic [7:0] ptr;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   i2c_reg_bank u_dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .txn_start_i (txn_start),
      .wr_valid_i  (wr_valid),
      .wr_data_i   (wr_data),
      .rd_req_i    (rd_req),
      .rd_valid_o  (rd_valid),
      .rd_data_o   (rd_data),
      .txn_stop_i  (txn_stop),
      .evt_i       (evt),
      .led_o       (led),
      .irq_o       (irq),
      .ptr_o       (ptr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every rd_valid pulse is matched against the oldest expected byte.
   always @(negedge clk) begin
      if (!rst && rd_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               bad++;
               $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      txn_start = 1'b0;
      wr_valid  = 1'b0;
      rd_req    = 1'b0;
      txn_stop  = 1'b0;
   endtask

   task automatic start();
      txn_start = 1'b1;
      tick();
   endtask

   task automatic stop();
      txn_stop = 1'b1;
      tick();
   endtask

   task automatic wr(input logic [7:0] b);
      wr_valid = 1'b1;
      wr_data  = b;
      tick();
   endtask

   task automatic rd(input logic [7:0] e);
      exp_q.push_back(e);
      rd_req = 1'b1;
      tick();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_led", led, 8'hFF);
      check("rst_irq", irq, 1'b1);
      check("rst_ptr", ptr, 8'h00);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);

      rd(8'hA5);
      check("ptr_after_idle_read", ptr, 8'h01);

      start(); wr(8'h04); wr(8'h11); wr(8'h22); stop();
      start(); wr(8'h04); rd(8'h11); rd(8'h22); stop();
      check("ptr_after_burst", ptr, 8'h06);

      start(); wr(8'h31); wr(8'hAA); wr(8'hBB); stop();
      check("ptr_after_wrap", ptr, 8'h01);
      start(); wr(8'h31); rd(8'hAA); rd(8'hA5); stop();

      start(); wr(8'h40);
      check("ptr_after_ovf", ptr, 8'h00);
      stop();
      start(); wr(8'h01); rd(8'h80); stop();
      start(); wr(8'h01); wr(8'h80); stop();
      start(); wr(8'h01); rd(8'h00); stop();

      start(); wr(8'h02); wr(8'h3C);
      check("led_write", led, 8'h3C);
      stop();

      start(); wr(8'h03); wr(8'h01); stop();
      check("irq_idle_masked", irq, 1'b1);
      evt = 6'h01;
      tick();
      evt = 6'h00;
      check("irq_not_yet", irq, 1'b1);
      tick();
      check("irq_asserted", irq, 1'b0);

      start(); wr(8'h01);
      evt = 6'h01;
      wr(8'h01);
      evt = 6'h00;
      stop();
      start(); wr(8'h01); rd(8'h01); stop();
      check("irq_held", irq, 1'b0);
      start(); wr(8'h01); wr(8'h01); stop();
      tick();
      check("irq_cleared", irq, 1'b1);
      start(); wr(8'h01); rd(8'h00); stop();

      start(); wr(8'h05);
      wr_valid = 1'b1;
      wr_data  = 8'h77;
      rd_req   = 1'b1;
      tick();
      stop();
      check("ptr_after_coll", ptr, 8'h06);
      start(); wr(8'h05); rd(8'h77); stop();
      start(); wr(8'h01); rd(8'h40); stop();

      repeat (3) tick();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
